posedge_window_ctrl: RTL and testbench

- Gated edge-measurement controller for the rising-edge counter datapath.
- Takes NUM_SIG asynchronous input signals, synchronises them to axi_clk, and counts rising edges on enabled channels over a programmable window of axi_clk cycles.
- Uses a start/busy/done handshake and presents a stable snapshot of results to the register interface.
- Replaces free-running edge-clocked counters with a single-clock, software-sequenced measurement.

---
 rtl/posedge_ctrl_pkg.sv | 36 +++
 rtl/posedge_sync_detect.sv | 37 +++
 rtl/posedge_window_ctrl.sv | 155 +++++++++++++++
 tb/tb_posedge_window_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posedge_ctrl_pkg.sv
// Shared types and helpers for the posedge window measurement controller.
//   state_t  : measurement FSM states
//   WIN_W    : width of the window length / window counter
//   sat_inc  : saturating increment on a SAT_W-wide value, with a saturate flag
package posedge_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    LATCH = 2'd3
  } state_t;

  localparam int unsigned WIN_W = 32;
  localparam int unsigned SAT_W = 32;

  typedef struct packed {
    logic             sat;
    logic [SAT_W-1:0] val;
  } sat_res_t;

  // Increment cnt unless it already sits at max; a request at max flags saturation.
  function automatic sat_res_t sat_inc(input logic [SAT_W-1:0] cnt,
                                       input logic [SAT_W-1:0] max);
    sat_res_t r;
    if (cnt >= max) begin
      r.sat = 1'b1;
      r.val = max;
    end else begin
      r.sat = 1'b0;
      r.val = cnt + SAT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/posedge_sync_detect.sv
// Per-channel synchroniser and rising-edge detector.
//   axi_clk, axi_resetn : clock, async active-low reset
//   async_in            : asynchronous input
//   rearm               : high for the re-arm cycle; prev is reloaded from sync_out
//                         and no pulse is reported during that cycle
//   edge_pulse          : one-cycle pulse, sync_out=1 while prev=0
module posedge_sync_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic axi_clk,
  input  logic axi_resetn,
  input  logic async_in,
  input  logic rearm,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchroniser chain plus previous-value flop; prev follows sync_out every
  // cycle, which is exactly the re-arm load, so rearm only has to gate the pulse.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_out;
    end
  end

  assign edge_pulse = sync_out & ~prev_q & ~rearm;

endmodule

// File: rtl/posedge_window_ctrl.sv
// Software-sequenced rising-edge counter over a window of axi_clk cycles.
//   axi_clk, axi_resetn : clock, async active-low reset
//   input_signals       : NUM_SIG asynchronous inputs
//   start, abort        : single-cycle measurement requests
//   window_len          : window length in cycles, latched on accepted start
//   enable_mask         : per-channel count enable, latched on accepted start
//   busy                : measurement in progress
//   done                : sticky result-valid flag, cleared by the next accepted start
//   overflow            : per-channel saturation flags of last completed window
//   count_o             : per-channel counts of last completed window, channel i at
//                         [i*CNT_W +: CNT_W]
// CNT_W must not exceed 32.
module posedge_window_ctrl
  import posedge_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SIG     = 8,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     axi_clk,
  input  logic                     axi_resetn,
  input  logic [NUM_SIG-1:0]       input_signals,
  input  logic                     start,
  input  logic                     abort,
  input  logic [WIN_W-1:0]         window_len,
  input  logic [NUM_SIG-1:0]       enable_mask,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_SIG-1:0]       overflow,
  output logic [NUM_SIG*CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_q;
  logic [WIN_W-1:0]   win_q;
  logic [WIN_W-1:0]   len_q;
  logic [NUM_SIG-1:0] mask_q;
  logic [NUM_SIG-1:0] edge_pulse;

  logic clr_c;
  logic rearm_c;
  logic count_en_c;
  logic latch_c;

  assign clr_c      = (state_q == IDLE) && start && !abort;
  assign rearm_c    = (state_q == ARM);
  assign count_en_c = (state_q == COUNT);
  assign latch_c    = (state_q == LATCH);

  // Measurement sequencer: start/abort handshake, window timing, busy/done.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q <= IDLE;
      win_q   <= '0;
      len_q   <= '0;
      mask_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q <= ARM;
            len_q   <= window_len;
            mask_q  <= enable_mask;
            done    <= 1'b0;
          end
        end
        ARM: begin
          if (abort) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else begin
            busy <= 1'b1;
            if (len_q == '0) begin
              state_q <= LATCH;
            end else begin
              state_q <= COUNT;
              win_q   <= len_q;
            end
          end
        end
        COUNT: begin
          if (abort) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else if (win_q == WIN_W'(1)) begin
            state_q <= LATCH;
          end else begin
            win_q <= win_q - WIN_W'(1);
          end
        end
        LATCH: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_SIG; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic [CNT_W-1:0] snap_cnt_q;
    logic             snap_ovf_q;
    sat_res_t         inc_res;

    posedge_sync_detect #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_det (
      .axi_clk    (axi_clk),
      .axi_resetn (axi_resetn),
      .async_in   (input_signals[i]),
      .rearm      (rearm_c),
      .edge_pulse (edge_pulse[i])
    );

    assign inc_res = sat_inc(SAT_W'(cnt_q), SAT_W'(CNT_MAX));

    // The increment never exceeds CNT_MAX, so the upper result bits are always zero.
    if (CNT_W < SAT_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = |inc_res.val[SAT_W-1:CNT_W];
    end

    // Working counter for the open window and the snapshot presented to software.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
        cnt_q      <= '0;
        ovf_q      <= 1'b0;
        snap_cnt_q <= '0;
        snap_ovf_q <= 1'b0;
      end else begin
        if (clr_c) begin
          cnt_q <= '0;
          ovf_q <= 1'b0;
        end else if (count_en_c && mask_q[i] && edge_pulse[i]) begin
          cnt_q <= CNT_W'(inc_res.val);
          ovf_q <= ovf_q | inc_res.sat;
        end
        if (latch_c) begin
          snap_cnt_q <= cnt_q;
          snap_ovf_q <= ovf_q;
        end
      end
    end

    assign count_o[i*CNT_W +: CNT_W] = snap_cnt_q;
    assign overflow[i]               = snap_ovf_q;
  end

endmodule

// File: tb/tb_posedge_window_ctrl.sv
// Scoreboard bench for posedge_window_ctrl. Inputs are driven once per cycle and
// logged; the reference counts 0->1 transitions of that log inside the sample
// window implied by the start edge, window length and synchroniser depth.
module tb_posedge_window_ctrl;

  localparam int unsigned NS   = 8;
  localparam int unsigned CW   = 32;
  localparam int unsigned SS   = 2;
  localparam int          HMAX = 8192;
  localparam longint      CMAX = longint'((64'd1 << CW) - 64'd1);

  logic            axi_clk = 1'b0;
  logic            axi_resetn;
  logic [NS-1:0]   input_signals;
  logic            start, abort;
  logic [31:0]     window_len;
  logic [NS-1:0]   enable_mask;
  logic            busy, done;
  logic [NS-1:0]   overflow;
  logic [NS*CW-1:0] count_o;

  // Narrow-counter instance for saturation.
  logic [1:0]  in4 = '0;
  logic        start4 = 1'b0, abort4 = 1'b0;
  logic [31:0] wl4 = '0;
  logic [1:0]  mask4 = '0;
  logic        busy4, done4;
  logic [1:0]  ovf4;
  logic [7:0]  cnt4;

  posedge_window_ctrl #(.NUM_SIG(NS), .CNT_W(CW), .SYNC_STAGES(SS)) dut (
    .axi_clk(axi_clk), .axi_resetn(axi_resetn), .input_signals(input_signals),
    .start(start), .abort(abort), .window_len(window_len), .enable_mask(enable_mask),
    .busy(busy), .done(done), .overflow(overflow), .count_o(count_o));

  posedge_window_ctrl #(.NUM_SIG(2), .CNT_W(4), .SYNC_STAGES(SS)) dut4 (
    .axi_clk(axi_clk), .axi_resetn(axi_resetn), .input_signals(in4),
    .start(start4), .abort(abort4), .window_len(wl4), .enable_mask(mask4),
    .busy(busy4), .done(done4), .overflow(ovf4), .count_o(cnt4));

  always #5 axi_clk = ~axi_clk;

  int cyc = 0;
  always @(posedge axi_clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- input generation and log ----------------
  int           mode = 0;      // 0 hold, 1 random, 2 periodic, 3 pulses
  int           base = 0;
  int           npulse = 7;
  logic [7:0]   hold_val = '0;
  logic [7:0]   hist [0:HMAX-1];

  always @(negedge axi_clk) begin
    logic [7:0] v;
    int k;
    k = cyc + 1 - base;
    v = '0;
    case (mode)
      0: v = hold_val;
      1: v = input_signals ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      2: for (int i = 0; i < 8; i++) v[i] = (k >= 0) && (((k / (2 * (i + 1))) % 2) == 1);
      default: begin
        v[1] = (k >= 0) && (((k / 2) % 2) == 1);
        v[0] = (k >= 1) && (k < 6 * npulse) && ((k % 6) == 1);
        v[2] = v[0];
      end
    endcase
    input_signals = v;
    if (cyc + 1 < HMAX) hist[cyc + 1] = v;
  end

  // Value sampled at edge e is counted at edge e+SS, which must fall in the
  // COUNT edges s+2 .. s+wl+1 of a measurement started at edge s.
  function automatic void model(input int s, input int wl, input logic [7:0] mask,
                                output logic [255:0] cnt, output logic [7:0] ovf);
    longint n;
    cnt = '0;
    ovf = '0;
    for (int ch = 0; ch < int'(NS); ch++) begin
      n = 0;
      if (mask[ch])
        for (int e = s + 2 - int'(SS); e <= s + wl + 1 - int'(SS); e++)
          if (hist[e][ch] && !hist[e-1][ch]) n++;
      if (n > CMAX) begin
        n = CMAX;
        ovf[ch] = 1'b1;
      end
      cnt[ch*32 +: 32] = 32'(n);
    end
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [255:0] cnt;
    logic [7:0]   ovf;
    int           dcyc;
    int           blen;
  } exp_t;

  exp_t         sbq[$];
  logic [255:0] last_cnt = '0;
  logic [7:0]   last_ovf = '0;

  initial begin : monitor
    logic done_q, busy_q;
    int   blen;
    exp_t x;
    done_q = 1'b0;
    busy_q = 1'b0;
    blen   = 0;
    forever begin
      @(negedge axi_clk);
      if (busy === 1'b1 && busy_q !== 1'b1) blen = 0;
      if (busy === 1'b1) blen++;
      if (done === 1'b1 && done_q !== 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 256'(sbq.size()), 256'(1));
        end else begin
          x = sbq.pop_front();
          chk("count_o", count_o, x.cnt);
          chk("overflow", 256'(overflow), 256'(x.ovf));
          chk("done_cycle", 256'(cyc), 256'(x.dcyc));
          chk("busy_len", 256'(blen), 256'(x.blen));
          chk("busy_at_done", 256'(busy), 256'(0));
        end
      end
      done_q = done;
      busy_q = busy;
    end
  end

  // ---------------- driver ----------------
  // ab: cycle offset of abort (-1 none); ab in 0..wl aborts, ab==wl+1 lands in LATCH.
  task automatic run_meas(input int wl, input logic [7:0] mask, input int ab,
                          input bit extra_start, input int md);
    int s;
    bit aborted;
    exp_t x;
    @(negedge axi_clk);
    mode = md;
    base = cyc + 2;
    @(negedge axi_clk);
    start = 1'b1;
    window_len = 32'(wl);
    enable_mask = mask;
    s = cyc + 1;
    aborted = (ab >= 0) && (ab <= wl);
    for (int t = s; t <= s + wl + 2; t++) begin
      @(negedge axi_clk);
      start = 1'b0;
      abort = 1'b0;
      if (t == s) begin
        chk("busy_in_arm", 256'(busy), 256'(0));
        chk("done_cleared", 256'(done), 256'(0));
      end
      if (t == s + 1 && ab != 0) chk("busy_rise", 256'(busy), 256'(1));
      if (extra_start && t == s + 3) begin
        start = 1'b1;
        window_len = 32'd7;
      end
      if (ab >= 0 && t == s + ab) abort = 1'b1;
      if (!aborted && t == s + wl) begin
        model(s, wl, mask, x.cnt, x.ovf);
        x.dcyc = s + wl + 2;
        x.blen = wl + 1;
        sbq.push_back(x);
        last_cnt = x.cnt;
        last_ovf = x.ovf;
      end
      if (aborted && t == s + ab + 1) begin
        chk("abort_busy", 256'(busy), 256'(0));
        chk("abort_done", 256'(done), 256'(0));
        chk("abort_count", count_o, last_cnt);
        chk("abort_ovf", 256'(overflow), 256'(last_ovf));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < HMAX; i++) hist[i] = '0;
    axi_resetn = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    window_len = '0;
    enable_mask = '0;
    repeat (5) @(negedge axi_clk);
    axi_resetn = 1'b1;

    // Idle after reset with toggling inputs.
    mode = 1;
    repeat (100) @(negedge axi_clk);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_count", count_o, 256'(0));
    chk("rst_ovf", 256'(overflow), 256'(0));

    // Periodic channels, full mask.
    run_meas(100, 8'hFF, -1, 1'b0, 2);
    for (int i = 0; i < int'(NS); i++) begin
      int d, e;
      d = int'(count_o[i*32 +: 32]);
      e = 100 / (4 * (i + 1));
      chk($sformatf("period_ch%0d_in_range", i), 256'((d >= e - 1) && (d <= e + 1)), 256'(1));
    end

    // Partial mask with pulsed channels.
    npulse = 7;
    run_meas(60, 8'h05, -1, 1'b0, 3);
    chk("mask_ch0", 256'(count_o[31:0]), 256'(7));
    chk("mask_ch1", 256'(count_o[63:32]), 256'(0));
    chk("mask_ch2", 256'(count_o[95:64]), 256'(7));

    // Zero-length window.
    run_meas(0, 8'hFF, -1, 1'b0, 1);

    // Channel already high before start is not counted.
    @(negedge axi_clk);
    mode = 0;
    hold_val = 8'h08;
    repeat (10) @(negedge axi_clk);
    run_meas(50, 8'hFF, -1, 1'b0, 0);
    chk("held_high_ch3", 256'(count_o[127:96]), 256'(0));
    hold_val = 8'h00;

    // Prior result of 5 on channel 0, then abort mid-window.
    npulse = 5;
    run_meas(40, 8'h01, -1, 1'b0, 3);
    chk("prior_ch0", 256'(count_o[31:0]), 256'(5));
    run_meas(100, 8'hFF, 30, 1'b0, 1);

    // Start while busy is ignored.
    run_meas(40, 8'hFF, -1, 1'b1, 1);

    // start and abort together in IDLE.
    @(negedge axi_clk);
    start = 1'b1;
    abort = 1'b1;
    window_len = 32'd10;
    @(negedge axi_clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge axi_clk);
    chk("start_abort_busy", 256'(busy), 256'(0));
    chk("start_abort_done", 256'(done), 256'(1));
    chk("start_abort_count", count_o, last_cnt);

    // Saturation on the narrow counter: 20 edges into a 4-bit counter.
    @(negedge axi_clk);
    start4 = 1'b1;
    wl4 = 32'd60;
    mask4 = 2'b11;
    @(negedge axi_clk);
    start4 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      in4[0] = (k % 2) == 1;
      @(negedge axi_clk);
    end
    in4 = '0;
    for (int k = 0; k < 80 && done4 !== 1'b1; k++) @(negedge axi_clk);
    chk("sat_done", 256'(done4), 256'(1));
    chk("sat_count", 256'(cnt4), 256'({4'd0, 4'd15}));
    chk("sat_ovf", 256'(ovf4), 256'(2'b01));

    // Randomised measurements, some aborted (including abort landing in LATCH).
    for (int n = 0; n < 15; n++) begin
      int wl, ab;
      wl = int'($urandom_range(0, 40));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, wl + 1)) : -1;
      npulse = int'($urandom_range(1, 8));
      run_meas(wl, 8'($urandom_range(0, 255)), ab, 1'b0, ($urandom_range(0, 1) == 0) ? 1 : 3);
    end

    // Reset in the middle of COUNT.
    @(negedge axi_clk);
    mode = 1;
    start = 1'b1;
    window_len = 32'd100;
    enable_mask = 8'hFF;
    @(negedge axi_clk);
    start = 1'b0;
    repeat (30) @(negedge axi_clk);
    mode = 0;
    hold_val = 8'h00;
    axi_resetn = 1'b0;
    #1;
    chk("midrst_busy", 256'(busy), 256'(0));
    chk("midrst_done", 256'(done), 256'(0));
    chk("midrst_count", count_o, 256'(0));
    chk("midrst_ovf", 256'(overflow), 256'(0));
    chk("midrst_done4", 256'(done4), 256'(0));
    chk("midrst_count4", 256'(cnt4), 256'(0));
    repeat (3) @(negedge axi_clk);
    axi_resetn = 1'b1;
    last_cnt = '0;
    last_ovf = '0;
    repeat (4) @(negedge axi_clk);
    run_meas(20, 8'hFF, -1, 1'b0, 1);

    repeat (3) @(negedge axi_clk);
    chk("scoreboard_drained", 256'(sbq.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
